// File: rtl/csr_timer_bank.sv
// csr_timer_bank: NUM_TIMERS independent down-counting CSR timers with
// one-shot/periodic modes, indexed config/clear/readback, debug halt,
// per-channel irq masking, and a free-running 64-bit stable counter.
module csr_timer_bank #(
   parameter int NUM_TIMERS = 4,
   parameter int CNT_W      = 32,
   parameter int IDX_W      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_we,
   input  logic [IDX_W-1:0]      cfg_idx,
   input  logic [CNT_W-1:0]      cfg_wdata,
   input  logic                  clr_we,
   input  logic [IDX_W-1:0]      clr_idx,
   input  logic                  clr_wdata,
   input  logic                  halt,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [CNT_W-1:0]      rd_tcfg,
   output logic [CNT_W-1:0]      rd_tval,
   input  logic [NUM_TIMERS-1:0] irq_mask,
   output logic [NUM_TIMERS-1:0] irq_pending,
   output logic                  irq,
   output logic [63:0]           stable_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONES = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0]      tcfg_q [NUM_TIMERS];
   logic [CNT_W-1:0]      tcfg_d [NUM_TIMERS];
   logic [CNT_W-1:0]      cnt_q  [NUM_TIMERS];
   logic [CNT_W-1:0]      cnt_d  [NUM_TIMERS];
   logic [NUM_TIMERS-1:0] pending_q;
   logic [NUM_TIMERS-1:0] pending_d;
   logic [63:0]           stable_q;
   logic [63:0]           stable_d;

   // Indices at or beyond NUM_TIMERS never match any channel, so such
   // writes are dropped and such reads return zero.
   function automatic logic idx_hit(input logic [IDX_W-1:0] idx, input int ch);
      return (int'(idx) == ch);
   endfunction

   // Reload value: InitVal occupies the upper bits, scaled by 4.
   function automatic logic [CNT_W-1:0] init_cnt(input logic [CNT_W-1:0] cfg);
      return {cfg[CNT_W-1:2], 2'b00};
   endfunction

   // Per-channel next state: cfg write beats halt, halt beats counting.
   always_comb begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
         tcfg_d[i] = tcfg_q[i];
         cnt_d[i]  = cnt_q[i];
         if (cfg_we && idx_hit(cfg_idx, i)) begin
            tcfg_d[i] = cfg_wdata;
            if (cfg_wdata[0]) begin
               cnt_d[i] = init_cnt(cfg_wdata);
            end
         end else if (!halt && tcfg_q[i][0] && (cnt_q[i] != CNT_ONES)) begin
            if ((cnt_q[i] == '0) && tcfg_q[i][1]) begin
               cnt_d[i] = init_cnt(tcfg_q[i]);
            end else begin
               // One-shot wraps 0 -> all-ones and parks there.
               cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
         end
      end
   end

   // Pending flags: the set term sees registered state only, so halt does
   // not suppress it, and set wins over a same-cycle clear.
   always_comb begin
      pending_d = pending_q;
      for (int i = 0; i < NUM_TIMERS; i++) begin
         if (tcfg_q[i][0] && (cnt_q[i] == '0)) begin
            pending_d[i] = 1'b1;
         end else if (clr_we && clr_wdata && idx_hit(clr_idx, i)) begin
            pending_d[i] = 1'b0;
         end
      end
   end

   // Free-running counter, unaffected by halt.
   always_comb begin
      stable_d = stable_q + 64'd1;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_TIMERS; i++) begin
            tcfg_q[i] <= '0;
            cnt_q[i]  <= CNT_ONES;
         end
         pending_q <= '0;
         stable_q  <= '0;
      end else begin
         tcfg_q    <= tcfg_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         stable_q  <= stable_d;
      end
   end

   // Combinational readback of the selected channel.
   always_comb begin
      rd_tcfg = '0;
      rd_tval = '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
         if (idx_hit(rd_idx, i)) begin
            rd_tcfg = tcfg_q[i];
            rd_tval = cnt_q[i];
         end
      end
   end

   assign irq_pending = pending_q;
   assign irq         = |(pending_q & irq_mask);
   assign stable_cnt  = stable_q;

endmodule

// File: tb/tb_csr_timer_bank.sv
// Self-checking bench for csr_timer_bank (NUM_TIMERS=4, CNT_W=32).
module tb_csr_timer_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_we;
   logic [1:0]  cfg_idx;
   logic [31:0] cfg_wdata;
   logic        clr_we;
   logic [1:0]  clr_idx;
   logic        clr_wdata;
   logic        halt;
   logic [1:0]  rd_idx;
   logic [31:0] rd_tcfg;
   logic [31:0] rd_tval;
   logic [3:0]  irq_mask;
   logic [3:0]  irq_pending;
   logic        irq;
   logic [63:0] stable_cnt;

   int n_chk = 0;
   int n_err = 0;

   csr_timer_bank #(.NUM_TIMERS(4), .CNT_W(32), .IDX_W(2)) dut (
      .clk(clk), .reset(reset),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata),
      .clr_we(clr_we), .clr_idx(clr_idx), .clr_wdata(clr_wdata),
      .halt(halt), .rd_idx(rd_idx), .rd_tcfg(rd_tcfg), .rd_tval(rd_tval),
      .irq_mask(irq_mask), .irq_pending(irq_pending), .irq(irq),
      .stable_cnt(stable_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        cfg_we;
      logic [1:0]  cfg_idx;
      logic [31:0] cfg_wdata;
      logic        clr_we;
      logic [1:0]  clr_idx;
      logic        clr_wdata;
      logic        halt;
      logic [1:0]  rd_idx;
      logic [3:0]  mask;
      logic [31:0] e_tval;
      logic [3:0]  e_pend;
      logic        e_irq;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input string nm, input logic cw, input logic [1:0] ci,
                               input logic [31:0] cd, input logic lw, input logic [1:0] li,
                               input logic h, input logic [1:0] ri, input logic [3:0] m,
                               input logic [31:0] et, input logic [3:0] ep, input logic ei);
      vec_t v;
      v.name = nm; v.cfg_we = cw; v.cfg_idx = ci; v.cfg_wdata = cd;
      v.clr_we = lw; v.clr_idx = li; v.clr_wdata = lw; v.halt = h;
      v.rd_idx = ri; v.mask = m; v.e_tval = et; v.e_pend = ep; v.e_irq = ei;
      return v;
   endfunction

   function automatic vec_t idle(input string nm, input logic [1:0] ri, input logic [3:0] m,
                                 input logic [31:0] et, input logic [3:0] ep, input logic ei);
      return mk(nm, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0, ri, m, et, ep, ei);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one vector, queue its expectation, retire it after the edge.
   task automatic apply(input vec_t v);
      vec_t e;
      cfg_we = v.cfg_we; cfg_idx = v.cfg_idx; cfg_wdata = v.cfg_wdata;
      clr_we = v.clr_we; clr_idx = v.clr_idx; clr_wdata = v.clr_wdata;
      halt = v.halt; rd_idx = v.rd_idx; irq_mask = v.mask;
      sb.push_back(v);
      tick();
      e = sb.pop_front();
      chk({e.name, " tval"}, 64'(rd_tval), 64'(e.e_tval));
      chk({e.name, " pend"}, 64'(irq_pending), 64'(e.e_pend));
      chk({e.name, " irq"}, 64'(irq), 64'(e.e_irq));
      cfg_we = 1'b0; clr_we = 1'b0; clr_wdata = 1'b0; halt = 1'b0;
   endtask

   initial begin
      logic [63:0] st_before;
      vec_t v;
      bit p1;

      reset = 1'b1; cfg_we = 0; cfg_idx = 0; cfg_wdata = 0; clr_we = 0; clr_idx = 0;
      clr_wdata = 0; halt = 0; rd_idx = 0; irq_mask = 4'hF;

      // ---------------- reset state
      tick(); tick();
      for (int i = 0; i < 4; i++) begin
         rd_idx = 2'(i);
         #1;
         chk($sformatf("reset tval ch%0d", i), 64'(rd_tval), 64'hFFFF_FFFF);
         chk($sformatf("reset tcfg ch%0d", i), 64'(rd_tcfg), 64'h0);
      end
      chk("reset pend", 64'(irq_pending), 64'h0);
      chk("reset irq", 64'(irq), 64'h0);
      chk("reset stable", stable_cnt, 64'h0);
      reset = 1'b0; irq_mask = 4'h0; rd_idx = 0;
      tick();
      chk("stable after release", stable_cnt, 64'h1);

      // ---------------- table: one-shot ch0 InitVal=3, then periodic ch1 InitVal=2
      tbl.push_back(mk("os wr", 1, 2'd0, 32'h0D, 0, 2'd0, 0, 2'd0, 4'b0001, 32'd12, 4'b0000, 0));
      for (int k = 1; k <= 12; k++)
         tbl.push_back(idle($sformatf("os k=%0d", k), 2'd0, 4'b0001, 32'(12 - k), 4'b0000, 0));
      for (int k = 13; k <= 15; k++)
         tbl.push_back(idle($sformatf("os k=%0d", k), 2'd0, 4'b0001, 32'hFFFF_FFFF, 4'b0001, 1));
      tbl.push_back(mk("os clr", 0, 2'd0, 32'h0, 1, 2'd0, 0, 2'd0, 4'b0001, 32'hFFFF_FFFF, 4'b0000, 0));
      tbl.push_back(mk("os dis", 1, 2'd0, 32'h0, 0, 2'd0, 0, 2'd0, 4'b0001, 32'hFFFF_FFFF, 4'b0000, 0));
      tbl.push_back(mk("per wr", 1, 2'd1, 32'h0B, 0, 2'd0, 0, 2'd1, 4'b0010, 32'd8, 4'b0000, 0));
      for (int k = 1; k <= 20; k++) begin
         p1 = (k == 9) || (k >= 18);
         tbl.push_back(mk($sformatf("per k=%0d", k), 0, 2'd0, 32'h0, (k == 10), 2'd1, 0, 2'd1,
                          4'b0010, 32'(8 - (k % 9)), {2'b00, p1, 1'b0}, p1));
      end
      tbl.push_back(mk("per dis+clr", 1, 2'd1, 32'h0, 1, 2'd1, 0, 2'd1, 4'b0010, 32'd6, 4'b0000, 0));
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
      rd_idx = 2'd1; #1;
      chk("per tcfg after disable", 64'(rd_tcfg), 64'h0);

      // ---------------- clear/set collision on ch2 (InitVal=1 one-shot)
      apply(mk("col wr", 1, 2'd2, 32'h05, 0, 2'd0, 0, 2'd2, 4'b0100, 32'd4, 4'b0000, 0));
      rd_idx = 2'd2; #1;
      chk("col tcfg", 64'(rd_tcfg), 64'h05);
      for (int k = 1; k <= 4; k++)
         apply(idle($sformatf("col k=%0d", k), 2'd2, 4'b0100, 32'(4 - k), 4'b0000, 0));
      apply(mk("col clr@zero", 0, 2'd0, 32'h0, 1, 2'd2, 0, 2'd2, 4'b0100, 32'hFFFF_FFFF, 4'b0100, 1));
      v = mk("clr bit0=0", 0, 2'd0, 32'h0, 1, 2'd2, 0, 2'd2, 4'b0100, 32'hFFFF_FFFF, 4'b0100, 1);
      v.clr_wdata = 1'b0;
      apply(v);
      apply(mk("col clr", 0, 2'd0, 32'h0, 1, 2'd2, 0, 2'd2, 4'b0100, 32'hFFFF_FFFF, 4'b0000, 0));

      // ---------------- halt on ch2 (InitVal=3), 5 frozen cycles
      apply(mk("halt wr", 1, 2'd2, 32'h0D, 0, 2'd0, 0, 2'd2, 4'b0100, 32'd12, 4'b0000, 0));
      apply(idle("halt pre1", 2'd2, 4'b0100, 32'd11, 4'b0000, 0));
      apply(idle("halt pre2", 2'd2, 4'b0100, 32'd10, 4'b0000, 0));
      st_before = stable_cnt;
      for (int k = 0; k < 5; k++)
         apply(mk($sformatf("halted %0d", k), 0, 2'd0, 32'h0, 0, 2'd0, 1, 2'd2, 4'b0100,
                  32'd10, 4'b0000, 0));
      chk("stable during halt", stable_cnt - st_before, 64'd5);
      for (int k = 0; k < 10; k++)
         apply(idle($sformatf("halt post %0d", k), 2'd2, 4'b0100, 32'(9 - k), 4'b0000, 0));
      apply(idle("halt fire", 2'd2, 4'b0100, 32'hFFFF_FFFF, 4'b0100, 1));
      apply(mk("halt clr", 0, 2'd0, 32'h0, 1, 2'd2, 0, 2'd2, 4'b0100, 32'hFFFF_FFFF, 4'b0000, 0));

      // ---------------- parallel channels
      apply(mk("par ch0 wr", 1, 2'd0, 32'h01, 0, 2'd0, 0, 2'd0, 4'b0000, 32'd0, 4'b0000, 0));
      apply(idle("par ch0 fire", 2'd0, 4'b0000, 32'hFFFF_FFFF, 4'b0001, 0));
      apply(mk("cfg keeps pend", 1, 2'd0, 32'h0, 0, 2'd0, 0, 2'd0, 4'b0000, 32'hFFFF_FFFF, 4'b0001, 0));
      apply(mk("cfg3+clr0", 1, 2'd3, 32'h05, 1, 2'd0, 0, 2'd3, 4'b0001, 32'd4, 4'b0000, 0));
      for (int k = 1; k <= 4; k++)
         apply(idle($sformatf("par3 k=%0d", k), 2'd3, 4'b0001, 32'(4 - k), 4'b0000, 0));
      apply(idle("par3 masked", 2'd3, 4'b0001, 32'hFFFF_FFFF, 4'b1000, 0));
      apply(idle("par3 unmasked", 2'd3, 4'b1000, 32'hFFFF_FFFF, 4'b1000, 1));

      // ---------------- reset mid-run
      for (int i = 0; i < 4; i++)
         apply(mk($sformatf("run wr ch%0d", i), 1, 2'(i), 32'h403, 0, 2'd0, 0, 2'(i), 4'hF,
                  32'h400, 4'b1000, 1));
      apply(idle("run ch3", 2'd3, 4'hF, 32'h3FF, 4'b1000, 1));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rd_idx = 2'(i);
         #1;
         chk($sformatf("midrst tval ch%0d", i), 64'(rd_tval), 64'hFFFF_FFFF);
         chk($sformatf("midrst tcfg ch%0d", i), 64'(rd_tcfg), 64'h0);
      end
      chk("midrst pend", 64'(irq_pending), 64'h0);
      chk("midrst irq", 64'(irq), 64'h0);
      chk("midrst stable", stable_cnt, 64'h0);
      for (int k = 1; k <= 3; k++)
         apply(idle($sformatf("post rst %0d", k), 2'd0, 4'hF, 32'hFFFF_FFFF, 4'b0000, 0));
      chk("post rst stable", stable_cnt, 64'd3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
